parity_rx_checker: RTL and testbench

//  Serial receiver/checker, the receive end of the 4-bit parity path: deserialises one

---
 rtl/parity_pkg.sv | 15 +
 rtl/parity_acc.sv | 24 ++
 rtl/parity_rx_checker.sv | 94 +++++++++
 tb/tb_parity_rx_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared constants for the parity generator/serialiser and receive checker.
package parity_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DATA   = 3'd1;
   localparam logic [2:0] ST_PARITY = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
   localparam logic [2:0] ST_BREAK  = 3'd4;

   localparam bit PARITY_EVEN = 1'b0;
   localparam bit PARITY_ODD  = 1'b1;

   localparam int DEFAULT_DATA_W = 4;

endpackage

// File: rtl/parity_acc.sv
// Purpose: 1-bit XOR parity accumulator with synchronous load and enable.
// Latency: acc reflects load/en one clk after the strobe.
// Backpressure: none; load wins over en, otherwise the value holds.
module parity_acc (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic load_val,
   input  logic en,
   input  logic din,
   output logic acc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= 1'b0;
      end else if (load) begin
         acc <= load_val;
      end else if (en) begin
         acc <= acc ^ din;
      end
   end

endmodule

// File: rtl/parity_rx_checker.sv
// Purpose: deserialise start/data(LSB first)/parity/stop frames and flag parity/framing errors.
// Latency: dout_valid pulses one clk after the bit_en cycle that samples the stop bit.
// Backpressure: none; every register advances only on bit_en, consumer must take the pulse.
module parity_rx_checker #(
   parameter int DATA_W     = parity_pkg::DEFAULT_DATA_W,
   parameter bit PARITY_ODD = parity_pkg::PARITY_EVEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_en,
   input  logic              sdin,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);
   import parity_pkg::*;

   localparam int              CNT_W = $clog2(DATA_W) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   logic [2:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] shreg;
   logic              perr_nxt;
   logic              acc;
   logic              acc_load;
   logic              acc_en;

   assign acc_load = bit_en && (state == ST_IDLE) && !sdin;
   assign acc_en   = bit_en && (state == ST_DATA);

   parity_acc u_acc (
      .clk      (clk),
      .rst      (rst),
      .load     (acc_load),
      .load_val (PARITY_ODD),
      .en       (acc_en),
      .din      (sdin),
      .acc      (acc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         shreg      <= '0;
         perr_nxt   <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         if (bit_en) begin
            case (state)
               ST_IDLE: begin
                  if (!sdin) begin
                     state <= ST_DATA;
                     cnt   <= '0;
                     shreg <= '0;
                     busy  <= 1'b1;
                  end
               end
               ST_DATA: begin
                  shreg <= shreg | (DATA_W'(sdin) << cnt);
                  cnt   <= cnt + 1'b1;
                  if (cnt == LAST) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  perr_nxt <= acc ^ sdin;
                  state    <= ST_STOP;
               end
               ST_STOP: begin
                  dout       <= shreg;
                  parity_err <= perr_nxt;
                  frame_err  <= ~sdin;
                  dout_valid <= 1'b1;
                  busy       <= 1'b0;
                  state      <= sdin ? ST_IDLE : ST_BREAK;
               end
               // A line held low after a bad stop bit must go high before a new start counts.
               ST_BREAK: begin
                  if (sdin) state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_parity_rx_checker.sv
// Directed bench: even and odd parity receivers driven from the same serial line.
module tb_parity_rx_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       bit_en;
   logic       sdin;
   logic [3:0] dout_e, dout_o;
   logic       vld_e, vld_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

   int n_cmp = 0;
   int n_bad = 0;
   int vcnt_e = 0;
   int vcnt_base;

   always #5 clk = ~clk;

   parity_rx_checker #(.DATA_W(4), .PARITY_ODD(1'b0)) u_even (
      .clk(clk), .rst(rst), .bit_en(bit_en), .sdin(sdin),
      .dout(dout_e), .dout_valid(vld_e), .parity_err(pe_e),
      .frame_err(fe_e), .busy(busy_e)
   );

   parity_rx_checker #(.DATA_W(4), .PARITY_ODD(1'b1)) u_odd (
      .clk(clk), .rst(rst), .bit_en(bit_en), .sdin(sdin),
      .dout(dout_o), .dout_valid(vld_o), .parity_err(pe_o),
      .frame_err(fe_o), .busy(busy_o)
   );

   always @(negedge clk) if (vld_e) vcnt_e++;

   typedef struct {
      logic [3:0] d;
      logic       p;
      logic [3:0] exp_dout;
      logic       exp_pe;
      logic       exp_po;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bit strobe, then gap cycles with bit_en low and sdin toggled to prove it is ignored.
   task automatic send_bit(input logic b, input int gap);
      sdin   = b;
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
      sdin   = ~b;
      for (int g = 0; g < gap; g++) tick();
   endtask

   task automatic send_frame(input logic [3:0] d, input logic p, input logic stop, input int gap);
      send_bit(1'b0, gap);
      for (int i = 0; i < 4; i++) send_bit(d[i], gap);
      send_bit(p, gap);
      send_bit(stop, 0);
      sdin = 1'b1;
   endtask

   task automatic idle(input int n);
      sdin   = 1'b1;
      bit_en = 1'b1;
      for (int i = 0; i < n; i++) tick();
      bit_en = 1'b0;
   endtask

   initial begin
      vecs[0] = '{d:4'h5, p:1'b0, exp_dout:4'h5, exp_pe:1'b0, exp_po:1'b1};
      vecs[1] = '{d:4'h7, p:1'b0, exp_dout:4'h7, exp_pe:1'b1, exp_po:1'b0};
      vecs[2] = '{d:4'h9, p:1'b0, exp_dout:4'h9, exp_pe:1'b0, exp_po:1'b1};
      vecs[3] = '{d:4'h0, p:1'b1, exp_dout:4'h0, exp_pe:1'b1, exp_po:1'b0};
      vecs[4] = '{d:4'h0, p:1'b0, exp_dout:4'h0, exp_pe:1'b0, exp_po:1'b1};
      vecs[5] = '{d:4'hF, p:1'b1, exp_dout:4'hF, exp_pe:1'b1, exp_po:1'b0};
      vecs[6] = '{d:4'hE, p:1'b1, exp_dout:4'hE, exp_pe:1'b0, exp_po:1'b1};

      rst    = 1'b1;
      bit_en = 1'b0;
      sdin   = 1'b1;
      repeat (3) tick();
      check("rst_dout", 16'(dout_e), 16'h0);
      check("rst_valid", 16'(vld_e), 16'h0);
      check("rst_perr", 16'(pe_e), 16'h0);
      check("rst_ferr", 16'(fe_e), 16'h0);
      check("rst_busy", 16'(busy_e), 16'h0);
      rst = 1'b0;
      tick();

      // Low line without bit_en must not start a frame.
      sdin = 1'b0;
      repeat (3) tick();
      check("no_strobe_busy", 16'(busy_e), 16'h0);
      sdin = 1'b1;
      idle(2);

      for (int v = 0; v < 7; v++) begin
         vcnt_base = vcnt_e;
         send_bit(1'b0, 0);
         check($sformatf("v%0d_busy", v), 16'(busy_e), 16'h1);
         for (int i = 0; i < 4; i++) send_bit(vecs[v].d[i], 0);
         send_bit(vecs[v].p, 0);
         send_bit(1'b1, 0);
         sdin = 1'b1;
         check($sformatf("v%0d_valid", v), 16'(vld_e), 16'h1);
         check($sformatf("v%0d_dout", v), 16'(dout_e), 16'(vecs[v].exp_dout));
         check($sformatf("v%0d_perr_even", v), 16'(pe_e), 16'(vecs[v].exp_pe));
         check($sformatf("v%0d_perr_odd", v), 16'(pe_o), 16'(vecs[v].exp_po));
         check($sformatf("v%0d_ferr", v), 16'(fe_e), 16'h0);
         check($sformatf("v%0d_busy_end", v), 16'(busy_e), 16'h0);
         tick();
         check($sformatf("v%0d_pulse_end", v), 16'(vld_e), 16'h0);
         check($sformatf("v%0d_pulse_cnt", v), 16'(vcnt_e - vcnt_base), 16'h1);
         idle(2);
      end

      // Bad stop bit, line held low: one pulse, no phantom frame.
      vcnt_base = vcnt_e;
      send_frame(4'hC, 1'b0, 1'b0, 0);
      check("brk_ferr", 16'(fe_e), 16'h1);
      check("brk_dout", 16'(dout_e), 16'hC);
      sdin   = 1'b0;
      bit_en = 1'b1;
      repeat (10) tick();
      bit_en = 1'b0;
      check("brk_busy", 16'(busy_e), 16'h0);
      check("brk_pulses", 16'(vcnt_e - vcnt_base), 16'h1);
      idle(1);
      send_frame(4'h3, 1'b0, 1'b1, 0);
      check("brk_next_dout", 16'(dout_e), 16'h3);
      check("brk_next_ferr", 16'(fe_e), 16'h0);
      check("brk_next_perr", 16'(pe_e), 16'h0);
      tick();
      check("brk_total", 16'(vcnt_e - vcnt_base), 16'h2);
      idle(2);

      // 1-in-4 strobes; mid-frame state must hold across the gaps.
      vcnt_base = vcnt_e;
      send_bit(1'b0, 3);
      send_bit(1'b0, 3);
      check("slow_hold_busy", 16'(busy_e), 16'h1);
      check("slow_hold_dout", 16'(dout_e), 16'h3);
      send_bit(1'b1, 3);
      send_bit(1'b0, 3);
      send_bit(1'b1, 3);
      send_bit(1'b0, 3);
      send_bit(1'b1, 0);
      sdin = 1'b1;
      check("slow_valid", 16'(vld_e), 16'h1);
      check("slow_dout", 16'(dout_e), 16'hA);
      check("slow_perr", 16'(pe_e), 16'h0);
      repeat (3) tick();
      check("slow_pulses", 16'(vcnt_e - vcnt_base), 16'h1);
      check("slow_dout_hold", 16'(dout_e), 16'hA);

      // Back-to-back frames with no idle bit between them.
      vcnt_base = vcnt_e;
      send_frame(4'h1, 1'b1, 1'b1, 0);
      check("b2b_first_dout", 16'(dout_e), 16'h1);
      check("b2b_first_perr", 16'(pe_e), 16'h0);
      send_frame(4'h8, 1'b1, 1'b1, 0);
      check("b2b_second_dout", 16'(dout_e), 16'h8);
      check("b2b_second_perr", 16'(pe_e), 16'h0);
      check("b2b_second_podd", 16'(pe_o), 16'h1);
      tick();
      check("b2b_pulses", 16'(vcnt_e - vcnt_base), 16'h2);
      idle(2);

      // Reset after the second data bit of 4'hF.
      vcnt_base = vcnt_e;
      send_bit(1'b0, 0);
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_dout", 16'(dout_e), 16'h0);
      check("mid_rst_busy", 16'(busy_e), 16'h0);
      check("mid_rst_podd", 16'(pe_o), 16'h0);
      tick();
      rst = 1'b0;
      send_bit(1'b1, 0);
      send_bit(1'b1, 0);
      idle(2);
      check("mid_rst_no_pulse", 16'(vcnt_e - vcnt_base), 16'h0);
      send_frame(4'h6, 1'b0, 1'b1, 0);
      check("post_rst_dout", 16'(dout_e), 16'h6);
      check("post_rst_perr", 16'(pe_e), 16'h0);
      check("post_rst_ferr", 16'(fe_e), 16'h0);
      tick();
      check("post_rst_pulses", 16'(vcnt_e - vcnt_base), 16'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
